// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle ARMv8 control FSM that phases the datapath strobes
// and handles variable-latency memory handshakes. Optional macro: SEQ_ILLEGAL_TRAP_EN.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             memread,
  output logic             memwrite,
  output logic             ir_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             mem2reg,
  output logic [3:0]       aluop,
  output logic [2:0]       signop,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       fault
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [2:0] EXT_I    = 3'b000;
  localparam logic [2:0] EXT_D    = 3'b001;
  localparam logic [2:0] EXT_B    = 3'b010;
  localparam logic [2:0] EXT_CB   = 3'b011;
  localparam logic [2:0] EXT_MOVZ = 3'b100;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_MOVZ,
    C_B, C_CBZ, C_LDUR, C_STUR, C_ILL
  } cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, dec_cls;
  logic [1:0]        fault_q, fault_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              timed_out;

  logic       reg2loc_q, alusrc_q, mem2reg_q;
  logic [3:0] aluop_q;
  logic [2:0] signop_q;
  logic       dec_reg2loc, dec_alusrc, dec_mem2reg;
  logic [3:0] dec_aluop;
  logic [2:0] dec_signop;

  // Opcode classes; x bits of the wider formats belong to the immediate fields.
  always_comb begin
    dec_cls = C_ILL;
    casez (opcode)
      11'b10001010000: dec_cls = C_AND;
      11'b10101010000: dec_cls = C_ORR;
      11'b10001011000: dec_cls = C_ADD;
      11'b11001011000: dec_cls = C_SUB;
      11'b1001000100?: dec_cls = C_ADDI;
      11'b1101000100?: dec_cls = C_SUBI;
      11'b110100101??: dec_cls = C_MOVZ;
      11'b000101?????: dec_cls = C_B;
      11'b10110100???: dec_cls = C_CBZ;
      11'b11111000010: dec_cls = C_LDUR;
      11'b11111000000: dec_cls = C_STUR;
      default:         dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    dec_reg2loc = 1'b0;
    dec_alusrc  = 1'b0;
    dec_mem2reg = 1'b0;
    dec_aluop   = ALU_AND;
    dec_signop  = EXT_I;
    case (dec_cls)
      C_AND: dec_aluop = ALU_AND;
      C_ORR: dec_aluop = ALU_ORR;
      C_ADD: dec_aluop = ALU_ADD;
      C_SUB: dec_aluop = ALU_SUB;
      C_ADDI: begin
        dec_alusrc = 1'b1;
        dec_aluop  = ALU_ADD;
      end
      C_SUBI: begin
        dec_alusrc = 1'b1;
        dec_aluop  = ALU_SUB;
      end
      C_MOVZ: begin
        dec_alusrc = 1'b1;
        dec_aluop  = ALU_PASSB;
        dec_signop = EXT_MOVZ;
      end
      C_B: begin
        dec_aluop  = ALU_PASSB;
        dec_signop = EXT_B;
      end
      // CBZ tests Rt through the ALU, so the second read port must select it.
      C_CBZ: begin
        dec_reg2loc = 1'b1;
        dec_aluop   = ALU_PASSB;
        dec_signop  = EXT_CB;
      end
      C_LDUR: begin
        dec_alusrc  = 1'b1;
        dec_mem2reg = 1'b1;
        dec_aluop   = ALU_ADD;
        dec_signop  = EXT_D;
      end
      C_STUR: begin
        dec_reg2loc = 1'b1;
        dec_alusrc  = 1'b1;
        dec_aluop   = ALU_ADD;
        dec_signop  = EXT_D;
      end
      default: ;
    endcase
  end

  assign wait_inc  = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + WAIT_W'(1);
  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LIM);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q   <= S_IDLE;
      fault_q   <= FLT_NONE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
          fault_d = FLT_TIMEOUT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_ILL) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
          state_d = S_FAULT;
          fault_d = FLT_ILLEGAL;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_B, C_CBZ:     state_d = S_FETCH;
          C_LDUR, C_STUR: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
        end else if (timed_out) begin
          state_d = S_FAULT;
          fault_d = FLT_TIMEOUT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the current state so a reset removes them at once.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_DECODE: begin
`ifndef SEQ_ILLEGAL_TRAP_EN
        pc_write = (dec_cls == C_ILL);
`endif
      end
      S_EXEC: begin
        if (cls_q == C_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else if (cls_q == C_CBZ) begin
          pc_write = 1'b1;
          pc_src   = zero;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        memread  = (cls_q == C_LDUR);
        memwrite = (cls_q == C_STUR);
        pc_write = dmem_ready && (cls_q == C_STUR);
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired_d = retired_q + CNT_W'(pc_write);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cls_q     <= C_ILL;
      reg2loc_q <= 1'b0;
      alusrc_q  <= 1'b0;
      mem2reg_q <= 1'b0;
      aluop_q   <= 4'b0000;
      signop_q  <= 3'b000;
    end else if (state_q == S_DECODE) begin
      cls_q     <= dec_cls;
      reg2loc_q <= dec_reg2loc;
      alusrc_q  <= dec_alusrc;
      mem2reg_q <= dec_mem2reg;
      aluop_q   <= dec_aluop;
      signop_q  <= dec_signop;
    end
  end

  assign reg2loc = reg2loc_q;
  assign alusrc  = alusrc_q;
  assign mem2reg = mem2reg_q;
  assign aluop   = aluop_q;
  assign signop  = signop_q;
  assign retired = retired_q;
  assign fault   = fault_q;

endmodule
